// File: rtl/cpu_state_sequencer_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcodes,
// write-back selects, halt causes and the sequencer's own instruction decode.
package cpu_state_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } seq_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] WB_RT = 2'd0;
  localparam logic [1:0] WB_RD = 2'd1;
  localparam logic [1:0] WB_RA = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_PC_LIMIT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_LOAD    = 2'd1,
    CLS_WRITE   = 2'd2,
    CLS_BRANCH  = 2'd3
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    logic [1:0] wb_sel;
  } decode_t;

  // Branches and jr retire straight from EXECUTE; everything else unlisted is illegal.
  function automatic decode_t decode_instr(input logic [5:0] op, input logic [5:0] fn);
    decode_t d;
    d.cls    = CLS_ILLEGAL;
    d.wb_sel = WB_RT;
    case (op)
      OP_LW:    d.cls = CLS_LOAD;
      OP_ADDIU: d.cls = CLS_WRITE;
      OP_JAL: begin
        d.cls    = CLS_WRITE;
        d.wb_sel = WB_RA;
      end
      OP_BEQ, OP_BNE: d.cls = CLS_BRANCH;
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SLT: begin
            d.cls    = CLS_WRITE;
            d.wb_sel = WB_RD;
          end
          FN_JR:   d.cls = CLS_BRANCH;
          default: d.cls = CLS_ILLEGAL;
        endcase
      end
      default: d.cls = CLS_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_state_sequencer_wait_timer.sv
// Wait-cycle counter shared by the FETCH and MEM handshakes; expired is high
// on the TIMEOUT-th cycle spent waiting in the current state.
module seq_wait_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle control FSM for the 8-bit MIPS-subset core: sequences fetch,
// decode, execute, memory and write-back, and halts stickily on errors.
module cpu_state_sequencer
  import cpu_state_sequencer_pkg::*;
#(
  parameter int MAX_PC  = 14,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       pc,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic [2:0]       state,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       error,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [8:0] MAX_PC_L = 9'(MAX_PC);

  seq_state_e       state_q, state_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic [1:0]       error_q, error_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;
  logic             wait_expired;
  logic             pc_over;
  decode_t          dec;

  assign pc_over = ({1'b0, pc} >= MAX_PC_L);
  assign dec     = decode_instr(opcode, func);

  seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .expired (wait_expired)
  );

  // An ack is checked before the timeout so a same-cycle ack always wins.
  always_comb begin
    state_d  = state_q;
    wb_sel_d = wb_sel_q;
    error_d  = error_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (pc_over) begin
          state_d = ST_HALT;
          error_d = ERR_PC_LIMIT;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            state_d = ST_DECODE;
          end else if (wait_expired) begin
            state_d = ST_HALT;
            error_d = ERR_TIMEOUT;
          end
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        case (dec.cls)
          CLS_LOAD: begin
            state_d  = ST_MEM;
            wb_sel_d = dec.wb_sel;
          end
          CLS_WRITE: begin
            state_d  = ST_WB;
            wb_sel_d = dec.wb_sel;
          end
          CLS_BRANCH: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: begin
            state_d = ST_HALT;
            error_d = ERR_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (wait_expired) begin
          state_d = ST_HALT;
          error_d = ERR_TIMEOUT;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    cycle_cnt_d = cycle_cnt_q;
    if (state_q != ST_IDLE && state_q != ST_HALT && cycle_cnt_q != '1) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
    instr_cnt_d = instr_cnt_q;
    if (retire && instr_cnt_q != '1) begin
      instr_cnt_d = instr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wb_sel_q    <= WB_RT;
      error_q     <= ERR_NONE;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_sel_q    <= wb_sel_d;
      error_q     <= error_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state     = state_q;
  assign wb_sel    = wb_sel_q;
  assign error     = error_q;
  assign halted    = (state_q == ST_HALT);
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit MIPS-subset core.
- Generates the 3-bit `state` bus consumed by the execute stage, which acts only when state==3.
- Handshakes with instruction and data memory, pulses the register-file write enable and selects the write-back destination.
- Halts on PC overflow, on an illegal instruction, or on a memory timeout.

Parameters:
- MAX_PC, 14, PC value at or above which fetch halts the core.
- TIMEOUT, 8, maximum cycles to wait for imem_ack or dmem_ack before an error halt.
- CNT_W, 16, width of the cycle and retired-instruction counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  leave IDLE and begin fetching
- pc  in  8  current PC from the execute stage
- opcode  in  6  decoded opcode of the latched instruction
- func  in  6  decoded func field
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instruction valid and latched this cycle
- dmem_req  out  1  data read request (lw only)
- dmem_ack  in  1  data valid this cycle
- state  out  3  0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEM, 5 WB, 6 HALT
- rf_we  out  1  register-file write pulse
- wb_sel  out  2  write destination: 0 rt, 1 rd, 2 $31
- halted  out  1  core stopped (sticky)
- error  out  2  halt cause: 0 none, 1 PC limit, 2 illegal instruction, 3 memory timeout
- cycle_cnt  out  CNT_W  active cycles
- instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - All outputs 0: imem_req, dmem_req, rf_we, wb_sel, halted, error, cycle_cnt, instr_cnt, and the wait counter.
  - Reset overrides every state, including mid-handshake and HALT.
- IDLE:
  - start=1 moves to FETCH next cycle; otherwise stay.
- FETCH:
  - If pc >= MAX_PC: go to HALT with error=1; imem_req stays 0 this cycle (combinational gate on pc).
  - Otherwise imem_req=1.
  - imem_ack=1 moves to DECODE.
  - If TIMEOUT cycles pass with no ack: go to HALT with error=3.
  - The wait counter clears on every state entry.
- DECODE:
  - Exactly 1 cycle, then EXECUTE.
- EXECUTE:
  - Exactly 1 cycle. Legality and the next state come from the sequencer's own decode of opcode/func; it does not use execute's instruction_invalid.
  - lw (0x23) goes to MEM.
  - addiu (0x09) and jal (0x03) go to WB.
  - R-type (0x00) with func addu 0x21 or slt 0x2A goes to WB.
  - beq (0x04), bne (0x05) and jr (R-type func 0x08) go to FETCH and retire.
  - Anything else goes to HALT with error=2 and does not retire.
- MEM:
  - dmem_req=1 until dmem_ack, then go to WB.
  - If TIMEOUT cycles pass with no ack: go to HALT with error=3.
- WB:
  - rf_we=1 for exactly 1 cycle, then FETCH; the instruction retires here.
  - wb_sel = 0 for addiu/lw, 1 for addu/slt, 2 for jal.
  - wb_sel is registered on EXECUTE exit and held until the next EXECUTE exit.
- HALT:
  - Sticky; halted=1; start is ignored. Only rst leaves HALT.
- Counters:
  - cycle_cnt increments every cycle the state is not IDLE or HALT.
  - instr_cnt increments on retire.
  - Both saturate at all-ones, with no wrap.
- Error precedence:
  - A single transition sets only one cause.
  - error is written only on entry to HALT and is never overwritten afterwards.
- Simultaneous events:
  - An ack arriving on the same cycle the wait counter reaches TIMEOUT counts as success (the ack wins).
  - start asserted in any state other than IDLE is ignored.
- PC timing:
  - execute updates pc 2 time units after the EXECUTE posedge.
  - The sequencer samples pc only in FETCH, at least one full cycle later.

Decomposition:
- Shared package holds:
  - state encodings (the value 3 is fixed as EXECUTE)
  - opcode/func constants: 0x09, 0x23, 0x04, 0x05, 0x03, 0x00, 0x21, 0x2A, 0x08
  - wb_sel codes and error codes
- One sub-module, seq_wait_timer: loadable counter with a TIMEOUT flag. It is shared by FETCH and MEM and cleared on state change.

Test Plan:
- Reset, start=1, then addiu with imem_ack immediate -> state sequence 1,2,3,5,1; rf_we high only in state 5; wb_sel=0; instr_cnt=1; cycle_cnt=4 on re-entry to FETCH.
- lw with dmem_ack delayed 3 cycles -> MEM held for 4 cycles with dmem_req=1; then WB with wb_sel=0; instr_cnt=1.
- beq, then jal, with pc=13 -> beq goes 3 to 1 with no rf_we; jal reaches WB with wb_sel=2; next fetch with pc=14 gives HALT, error=1, imem_req never asserted.
- opcode 0x00 with func 0x1F in EXECUTE -> HALT with error=2, instr_cnt unchanged, halted=1; later start=1 -> state stays 6.
- imem_ack held low for 8 cycles -> HALT with error=3. Separately, ack on exactly the 8th cycle -> DECODE.
- rst pulse while in MEM with dmem_req=1 -> next cycle state=0 with all outputs 0; a subsequent start restarts cleanly.
